// File: rtl/pixel_seq_pkg.sv
// pixel_seq_pkg
//   Shared types and default constants for the pixel array frame sequencer.
//   Contents:
//     seq_state_t   frame sequencer states
//     DEF_*         default parameter values for pixel_array_seq
//     maxInt        helper used to size shared pulse counters
package pixel_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    CLEAR,
    RAMP,
    STOP,
    READOUT,
    DONE
  } seq_state_t;

  localparam int DEF_NUM_PIX    = 8;
  localparam int DEF_CNT_BITS   = 10;
  localparam int DEF_RAMP_STEPS = 1023;
  localparam int DEF_CLR_CYC    = 2;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pixel_strobe_gen.sv
// pixel_strobe_gen
//   Generates a burst of Sh_clk pulses, each one clock high and one clock low,
//   for as long as i_en stays high. Dropping i_en restarts the burst.
//   Ports:
//     i_clk     system clock
//     i_rst     synchronous active-high reset
//     i_en      burst enable; low clears the generator
//     i_count   number of pulses in the burst
//     o_sh_clk  registered strobe output
//     o_rise    high in the cycle whose closing edge drives o_sh_clk 0->1
//     o_last    high while the final pulse of the burst is high
module pixel_strobe_gen #(
  parameter int CW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic [CW-1:0] i_count,
  output logic          o_sh_clk,
  output logic          o_rise,
  output logic          o_last
);

  logic          r_phase;
  logic [CW-1:0] r_cnt;

  // r_phase=0 means the next edge raises the strobe, r_phase=1 lowers it.
  // r_cnt counts pulses already raised in this burst.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en) begin
      r_phase  <= 1'b0;
      r_cnt    <= '0;
      o_sh_clk <= 1'b0;
    end else if (!r_phase) begin
      r_phase  <= 1'b1;
      r_cnt    <= r_cnt + 1'b1;
      o_sh_clk <= 1'b1;
    end else begin
      r_phase  <= 1'b0;
      o_sh_clk <= 1'b0;
    end
  end

  assign o_rise = i_en && !r_phase;
  assign o_last = r_phase && (r_cnt == i_count);

endmodule

// File: rtl/pixel_array_seq.sv
// pixel_array_seq
//   Frame sequencer for a serial chain of NUM_PIX in-pixel XNOR-LFSR counters.
//   Sequences clear, count and readout of the chain and deserialises Ser_Out
//   into one CNT_BITS word per pixel.
//   Optional feature macro: PIXSEQ_ABORT_EN (adds the Abort input).
//   Ports:
//     Clk, Rst    clock and synchronous active-high reset
//     Start       frame request, honoured only in IDLE
//     Ser_Out     serial output of the last pixel in the chain
//     clr_FF      clears pixel SR latches
//     Pix_clk     force-stop pulse at the end of the count phase
//     Phase3      selects gated Sh_clk as the pixel count clock
//     Shift       selects readout mode
//     Sh_clk      shared strobe to the chain
//     Ser_in      serial input of the first pixel, tied low
//     Busy        high whenever the sequencer is not idle
//     Data_out    deserialised pixel word
//     Data_valid  one-cycle qualifier for Data_out/Pix_idx
//     Pix_idx     chain position of Data_out, 0 nearest Ser_Out
//     Done        one-cycle end-of-frame pulse
//     Abort       (PIXSEQ_ABORT_EN only) abandons the current frame
module pixel_array_seq
  import pixel_seq_pkg::*;
#(
  parameter int NUM_PIX    = DEF_NUM_PIX,
  parameter int CNT_BITS   = DEF_CNT_BITS,
  parameter int RAMP_STEPS = DEF_RAMP_STEPS,
  parameter int CLR_CYC    = DEF_CLR_CYC
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       Start,
  input  logic                       Ser_Out,
  output logic                       clr_FF,
  output logic                       Pix_clk,
  output logic                       Phase3,
  output logic                       Shift,
  output logic                       Sh_clk,
  output logic                       Ser_in,
  output logic                       Busy,
  output logic [CNT_BITS-1:0]        Data_out,
  output logic                       Data_valid,
  output logic [$clog2(NUM_PIX)-1:0] Pix_idx,
  output logic                       Done
`ifdef PIXSEQ_ABORT_EN
  ,
  input  logic                       Abort
`endif
);

  localparam int READ_PULSES = NUM_PIX * CNT_BITS;
  localparam int PCW = $clog2(maxInt(RAMP_STEPS, READ_PULSES)) + 1;
  localparam int CCW = $clog2(CLR_CYC) + 1;
  localparam int BCW = $clog2(CNT_BITS) + 1;
  localparam int PIW = $clog2(NUM_PIX);
  localparam int PXW = $clog2(NUM_PIX) + 1;

  seq_state_t            r_state;
  seq_state_t            w_nextState;
  logic                  r_seeded;
  logic                  r_abortFlush;
  logic                  r_suppress;
  logic [CCW-1:0]        r_clrCnt;
  logic [BCW-1:0]        r_bitCnt;
  logic [PXW-1:0]        r_pixCnt;
  logic [CNT_BITS-2:0]   r_shreg;
  logic                  w_abort;
  logic                  w_pulseState;
  logic                  w_genEn;
  logic [PCW-1:0]        w_count;
  logic                  w_rise;
  logic                  w_last;

`ifdef PIXSEQ_ABORT_EN
  assign w_abort = Abort;
`else
  assign w_abort = 1'b0;
`endif

  assign Ser_in = 1'b0;

  assign w_pulseState = (r_state == FLUSH) || (r_state == RAMP) || (r_state == READOUT);
  // The generator is released on the cycle the state is about to change, so an
  // abort jump from RAMP into FLUSH starts a fresh burst instead of continuing
  // the count burst, and no Sh_clk rise lands on the cycle Shift switches.
  assign w_genEn = w_pulseState && (w_nextState == r_state);
  assign w_count = (r_state == RAMP) ? PCW'(RAMP_STEPS) : PCW'(READ_PULSES);

  pixel_strobe_gen #(
    .CW(PCW)
  ) u_strobe (
    .i_clk   (Clk),
    .i_rst   (Rst),
    .i_en    (w_genEn),
    .i_count (w_count),
    .o_sh_clk(Sh_clk),
    .o_rise  (w_rise),
    .o_last  (w_last)
  );

  // Next-state logic. Phase lengths come from the strobe generator's last-pulse
  // flag and the clear-cycle counter.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (Start) w_nextState = r_seeded ? CLEAR : FLUSH;
      FLUSH:   if (w_last) w_nextState = r_abortFlush ? IDLE : CLEAR;
      CLEAR: begin
        if (w_abort) w_nextState = FLUSH;
        else if (r_clrCnt == CCW'(CLR_CYC - 1)) w_nextState = RAMP;
      end
      RAMP: begin
        if (w_abort) w_nextState = FLUSH;
        else if (w_last) w_nextState = STOP;
      end
      STOP:    w_nextState = w_abort ? FLUSH : READOUT;
      READOUT: if (w_last) w_nextState = (r_suppress || w_abort) ? IDLE : DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // State register plus registered control outputs, all decoded from the next
  // state so they line up with the state they belong to.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state      <= IDLE;
      r_seeded     <= 1'b0;
      r_abortFlush <= 1'b0;
      r_suppress   <= 1'b0;
      r_clrCnt     <= '0;
      clr_FF       <= 1'b0;
      Pix_clk      <= 1'b0;
      Phase3       <= 1'b0;
      Shift        <= 1'b0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      clr_FF   <= (w_nextState == CLEAR);
      Pix_clk  <= (w_nextState == STOP);
      Phase3   <= (w_nextState == RAMP) || (w_nextState == STOP);
      Shift    <= (w_nextState == FLUSH) || (w_nextState == READOUT);
      Busy     <= (w_nextState != IDLE);
      Done     <= (w_nextState == DONE);
      r_clrCnt <= ((r_state == CLEAR) && (w_nextState == CLEAR)) ? r_clrCnt + 1'b1 : '0;
      if ((r_state == FLUSH) && (w_nextState != FLUSH)) r_seeded <= 1'b1;
      if (r_state == IDLE) r_abortFlush <= 1'b0;
      else if ((r_state != FLUSH) && (w_nextState == FLUSH)) r_abortFlush <= 1'b1;
      if (r_state == IDLE) r_suppress <= 1'b0;
      else if ((r_state == READOUT) && w_abort) r_suppress <= 1'b1;
    end
  end

  // Deserialiser: Ser_Out is captured on the edge that raises Sh_clk, so the
  // bit taken is the one the chain presented before shifting.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_bitCnt   <= '0;
      r_pixCnt   <= '0;
      r_shreg    <= '0;
      Data_out   <= '0;
      Pix_idx    <= '0;
      Data_valid <= 1'b0;
    end else begin
      Data_valid <= 1'b0;
      if (r_state != READOUT) begin
        r_bitCnt <= '0;
        r_pixCnt <= '0;
      end else if (w_rise) begin
        r_shreg <= {r_shreg[CNT_BITS-3:0], Ser_Out};
        if (r_bitCnt == BCW'(CNT_BITS - 1)) begin
          r_bitCnt <= '0;
          r_pixCnt <= r_pixCnt + 1'b1;
          if (!(r_suppress || w_abort)) begin
            Data_valid <= 1'b1;
            Data_out   <= {r_shreg, Ser_Out};
            Pix_idx    <= r_pixCnt[PIW-1:0];
          end
        end else begin
          r_bitCnt <= r_bitCnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_array_seq.sv
// tb_pixel_array_seq
//   Self-checking bench for pixel_array_seq with a short count phase.
//   The pixel chain is modelled as one long shift register loaded with the
//   counted values at the force-stop pulse and shifted by Sh_clk in readout.
module tb_pixel_array_seq;

  localparam int NUM_PIX    = 8;
  localparam int CNT_BITS   = 10;
  localparam int RAMP_STEPS = 5;
  localparam int CLR_CYC    = 2;
  localparam int CHAIN      = NUM_PIX * CNT_BITS;
  localparam int LIMIT      = 3000;

  logic                       Clk = 1'b0;
  logic                       Rst;
  logic                       Start;
  logic                       Ser_Out;
  logic                       clr_FF, Pix_clk, Phase3, Shift, Sh_clk, Ser_in;
  logic                       Busy, Data_valid, Done;
  logic [CNT_BITS-1:0]        Data_out;
  logic [$clog2(NUM_PIX)-1:0] Pix_idx;

  int checks = 0;
  int errors = 0;

  logic [CHAIN-1:0]    chain = '0;
  logic [CHAIN-1:0]    loadVal = '0;
  logic                loadReq = 1'b0;
  logic [CNT_BITS-1:0] expWord [NUM_PIX];

  int shiftRises = 0, rampRises = 0, clrCycles = 0, pixCycles = 0;
  int pixWithSh = 0, pixNoP3 = 0, doneCount = 0, dvCount = 0, violations = 0;
  int dvTarget = 0;
  logic [CNT_BITS-1:0]        obsWord [$];
  logic [$clog2(NUM_PIX)-1:0] obsIdx  [$];
  logic                       prevSh = 1'b0;
  logic [3:0]                 prevCtl = '0;

  always #5 Clk = ~Clk;

  pixel_array_seq #(
    .NUM_PIX   (NUM_PIX),
    .CNT_BITS  (CNT_BITS),
    .RAMP_STEPS(RAMP_STEPS),
    .CLR_CYC   (CLR_CYC)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Start     (Start),
    .Ser_Out   (Ser_Out),
    .clr_FF    (clr_FF),
    .Pix_clk   (Pix_clk),
    .Phase3    (Phase3),
    .Shift     (Shift),
    .Sh_clk    (Sh_clk),
    .Ser_in    (Ser_in),
    .Busy      (Busy),
    .Data_out  (Data_out),
    .Data_valid(Data_valid),
    .Pix_idx   (Pix_idx),
    .Done      (Done)
  );

  // Pixel chain: the pixel nearest Ser_Out sits in the top bits and leaves MSB first.
  assign Ser_Out = chain[CHAIN-1];

  always @(posedge Sh_clk or posedge loadReq) begin
    if (loadReq) chain <= loadVal;
    else if (Shift) chain <= {chain[CHAIN-2:0], Ser_in};
  end

  // Observer sampling on the falling clock edge, away from DUT updates.
  always @(negedge Clk) begin
    if (Sh_clk && !prevSh) begin
      if (Shift) shiftRises++;
      if (Phase3) rampRises++;
      if ({clr_FF, Pix_clk, Phase3, Shift} != prevCtl) violations++;
    end
    if (clr_FF) clrCycles++;
    if (Pix_clk) begin
      pixCycles++;
      if (Sh_clk) pixWithSh++;
      if (!Phase3) pixNoP3++;
    end
    if (Done) doneCount++;
    if (Data_valid) begin
      dvCount++;
      obsWord.push_back(Data_out);
      obsIdx.push_back(Pix_idx);
    end
    prevSh  = Sh_clk;
    prevCtl = {clr_FF, Pix_clk, Phase3, Shift};
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic rst, input int cycles);
    Start = start;
    Rst   = rst;
    repeat (cycles) @(negedge Clk);
    Start = 1'b0;
    Rst   = 1'b0;
  endtask

  function automatic logic evtHit(input int sel);
    case (sel)
      0: return clr_FF;
      1: return Pix_clk;
      2: return Done;
      3: return Phase3;
      4: return (dvCount >= dvTarget);
      default: return 1'b1;
    endcase
  endfunction

  task automatic waitEvent(input int sel, input string tag);
    int n = 0;
    while (!evtHit(sel) && n < LIMIT) begin
      @(negedge Clk);
      n++;
    end
    checkOutput(tag, {31'd0, evtHit(sel)}, 32'd1);
  endtask

  task automatic loadChain();
    for (int k = 0; k < NUM_PIX; k++)
      loadVal[(NUM_PIX-1-k)*CNT_BITS +: CNT_BITS] = expWord[k];
    loadReq = 1'b1;
    #1;
    loadReq = 1'b0;
  endtask

  task automatic checkWords(input int base);
    checkOutput("dv_count", dvCount - base, NUM_PIX);
    for (int k = 0; k < NUM_PIX && base + k < obsWord.size(); k++) begin
      checkOutput($sformatf("word%0d", k), {22'd0, obsWord[base+k]}, {22'd0, expWord[k]});
      checkOutput($sformatf("idx%0d", k), {29'd0, obsIdx[base+k]}, k);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_ctl"}, {26'd0, clr_FF, Pix_clk, Phase3, Shift, Sh_clk, Ser_in}, 0);
    checkOutput({tag, "_busy"}, {31'd0, Busy}, 0);
    checkOutput({tag, "_dv_done"}, {30'd0, Data_valid, Done}, 0);
    checkOutput({tag, "_data"}, {19'd0, Data_out, Pix_idx}, 0);
  endtask

  initial begin
    int shBase, dvBase, clrBase, rampBase, pixBase, doneBase;
    Rst = 1'b1;
    Start = 1'b0;
    applyStimulus(1'b0, 1'b1, 3);
    checkIdleOutputs("reset");

    // Frame 1: first frame after reset flushes the chain before clearing.
    for (int k = 0; k < NUM_PIX; k++) expWord[k] = CNT_BITS'(10'h2A5 + k);
    shBase = shiftRises; dvBase = dvCount; clrBase = clrCycles;
    rampBase = rampRises; pixBase = pixCycles; doneBase = doneCount;
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("busy_after_start", {31'd0, Busy}, 1);
    waitEvent(0, "clr_seen_f1");
    checkOutput("flush_pulses", shiftRises - shBase, CHAIN);
    checkOutput("flush_no_dv", dvCount - dvBase, 0);
    waitEvent(1, "pixclk_seen_f1");
    loadChain();
    shBase = shiftRises;
    waitEvent(2, "done_seen_f1");
    checkOutput("clr_cycles", clrCycles - clrBase, CLR_CYC);
    checkOutput("ramp_pulses", rampRises - rampBase, RAMP_STEPS);
    checkOutput("pixclk_cycles", pixCycles - pixBase, 1);
    checkOutput("pixclk_with_shclk", pixWithSh, 0);
    checkOutput("pixclk_without_phase3", pixNoP3, 0);
    checkOutput("readout_pulses", shiftRises - shBase, CHAIN);
    checkOutput("ser_in_low", {31'd0, Ser_in}, 0);
    checkWords(dvBase);
    applyStimulus(1'b0, 1'b0, 2);
    checkOutput("done_count_f1", doneCount - doneBase, 1);
    checkOutput("idle_after_f1", {31'd0, Busy}, 0);

    // Frame 2: already seeded, random counts, Start pulsed again mid-count.
    for (int k = 0; k < NUM_PIX; k++) expWord[k] = CNT_BITS'($urandom);
    shBase = shiftRises; dvBase = dvCount; clrBase = clrCycles; doneBase = doneCount;
    applyStimulus(1'b1, 1'b0, 1);
    waitEvent(3, "phase3_seen_f2");
    applyStimulus(1'b1, 1'b0, 1);
    waitEvent(1, "pixclk_seen_f2");
    checkOutput("no_flush_f2", shiftRises - shBase, 0);
    checkOutput("clr_cycles_f2", clrCycles - clrBase, CLR_CYC);
    loadChain();
    waitEvent(2, "done_seen_f2");
    checkWords(dvBase);
    applyStimulus(1'b0, 1'b0, 6);
    checkOutput("done_count_f2", doneCount - doneBase, 1);
    checkOutput("start_ignored_f2", {31'd0, Busy}, 0);

    // Frame 3: reset in the middle of readout, then the next frame flushes.
    for (int k = 0; k < NUM_PIX; k++) expWord[k] = CNT_BITS'($urandom);
    dvBase = dvCount;
    applyStimulus(1'b1, 1'b0, 1);
    waitEvent(1, "pixclk_seen_f3");
    loadChain();
    dvTarget = dvBase + 3;
    waitEvent(4, "dv_partial_f3");
    applyStimulus(1'b0, 1'b1, 1);
    checkIdleOutputs("midreset");
    for (int k = 0; k < NUM_PIX; k++) expWord[k] = CNT_BITS'($urandom);
    shBase = shiftRises; dvBase = dvCount; doneBase = doneCount;
    applyStimulus(1'b1, 1'b0, 1);
    waitEvent(0, "clr_seen_f4");
    checkOutput("reflush_pulses", shiftRises - shBase, CHAIN);
    checkOutput("reflush_no_dv", dvCount - dvBase, 0);
    waitEvent(1, "pixclk_seen_f4");
    loadChain();
    waitEvent(2, "done_seen_f4");
    checkWords(dvBase);
    applyStimulus(1'b0, 1'b0, 2);
    checkOutput("done_count_f4", doneCount - doneBase, 1);
    checkOutput("ctl_vs_rise", violations, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
